uart_tick_gen: RTL and testbench

- Parametrised successor to the fixed-divide UART clock: a multi-channel NCO that runs on the PLL-derived clock `osc_int` and produces UART ticks.
- Each channel produces a one-cycle oversample tick and a bit tick, at a rate set at run time by a phase increment.
- Ticks are qualified by PLL lock and standby, so downstream RS232 TX/RX logic never sees ticks from an unlocked or parked clock.
- Sits between the clock/PLL wrapper and the UART cores.

---
 rtl/uart_tick_pkg.sv | 23 ++
 rtl/nco_channel.sv | 67 ++++++
 rtl/uart_tick_gen.sv | 101 ++++++++++
 tb/tb_uart_tick_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tick_pkg.sv
// Shared types and helpers for the UART tick generator: FSM states and increment calculation.
package uart_tick_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2,
    ST_PARK      = 2'd3
  } state_t;

  localparam int ACC_W_DEF = 24;

  // round(baud * ovs * 2^acc_w / clk_hz); 64-bit intermediate covers practical clock/baud ranges
  function automatic longint unsigned inc_for(input longint unsigned clk_hz,
                                              input longint unsigned baud,
                                              input longint unsigned ovs,
                                              input int unsigned     acc_w);
    longint unsigned num;
    num = baud * ovs * (64'd1 << acc_w);
    return (num + clk_hz / 2) / clk_hz;
  endfunction

endpackage

// File: rtl/nco_channel.sv
// One NCO tick channel: increment register, phase accumulator, registered carry ticks and
// oversample counter. Ticks appear one cycle after the carry and only while staying in RUN.
module nco_channel
  import uart_tick_pkg::*;
#(
  parameter int                      ACC_W       = ACC_W_DEF,
  parameter int                      OVS         = 16,
  parameter logic [ACC_W-1:0]        INC_DEFAULT = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_run_nxt,
  input  logic             i_wr,
  input  logic [ACC_W-1:0] i_inc,
  output logic             o_ovs_tick,
  output logic             o_bit_tick
);

  localparam int OVS_W = $clog2(OVS);

  logic [ACC_W-1:0] r_inc;
  logic [ACC_W-1:0] r_acc;
  logic [OVS_W-1:0] r_ovs_cnt;
  logic             r_ovs_tick;
  logic             r_bit_tick;

  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic             w_clr;
  logic             w_keep;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_carry = i_run & w_sum[ACC_W];
  assign w_clr   = i_run_nxt & ~i_run;
  // A carry in the last RUN cycle must not leak out as a tick once the FSM has left RUN
  assign w_keep  = i_run & i_run_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inc      <= INC_DEFAULT;
      r_acc      <= '0;
      r_ovs_cnt  <= '0;
      r_ovs_tick <= 1'b0;
      r_bit_tick <= 1'b0;
    end else begin
      if (i_wr) begin
        r_inc <= i_inc;
      end
      if (w_clr) begin
        r_acc     <= '0;
        r_ovs_cnt <= '0;
      end else if (i_run) begin
        r_acc <= w_sum[ACC_W-1:0];
        if (w_carry) begin
          r_ovs_cnt <= r_ovs_cnt + OVS_W'(1);
        end
      end
      r_ovs_tick <= w_carry & w_keep;
      r_bit_tick <= w_carry & w_keep & (r_ovs_cnt == OVS_W'(OVS - 1));
    end
  end

  assign o_ovs_tick = r_ovs_tick;
  assign o_bit_tick = r_bit_tick;

endmodule

// File: rtl/uart_tick_gen.sv
// Multi-channel NCO UART tick generator on osc_int; ticks only flow once the PLL lock has
// settled and standby is released. Holds the lock/standby FSM and the increment write decode.
module uart_tick_gen
  import uart_tick_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          ACC_W       = ACC_W_DEF,
  parameter int          OVS         = 16,
  parameter int          LOCK_CYC    = 1024,
  parameter int unsigned INC_DEFAULT = 3022624,
  localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              osc_int,
  input  logic              rst,
  input  logic              stdby,
  input  logic              pll_lock,
  input  logic              inc_wr,
  input  logic [CH_W-1:0]   inc_ch,
  input  logic [ACC_W-1:0]  inc_data,
  output logic [NUM_CH-1:0] ovs_tick,
  output logic [NUM_CH-1:0] bit_tick,
  output logic              ready
);

  localparam int LOCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LOCK_W-1:0] r_settle_cnt;
  logic [NUM_CH-1:0] w_wr;
  logic              w_run;
  logic              w_run_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_LOCK: if (pll_lock) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!pll_lock) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_settle_cnt == LOCK_W'(LOCK_CYC - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!pll_lock) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (stdby) begin
          w_state_nxt = ST_PARK;
        end
      end
      ST_PARK: begin
        if (!pll_lock) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (!stdby) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  // Settle counter only runs while staying in SETTLE, so any lock loss restarts it
  always_ff @(posedge osc_int) begin
    if (rst) begin
      r_state      <= ST_WAIT_LOCK;
      r_settle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_SETTLE) && (w_state_nxt == ST_SETTLE)) begin
        r_settle_cnt <= r_settle_cnt + LOCK_W'(1);
      end else begin
        r_settle_cnt <= '0;
      end
    end
  end

  assign w_run     = (r_state == ST_RUN);
  assign w_run_nxt = (w_state_nxt == ST_RUN);
  assign ready     = w_run;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_wr[c] = inc_wr & (32'(inc_ch) == c);

    nco_channel #(
      .ACC_W       (ACC_W),
      .OVS         (OVS),
      .INC_DEFAULT (ACC_W'(INC_DEFAULT))
    ) u_ch (
      .i_clk      (osc_int),
      .i_rst      (rst),
      .i_run      (w_run),
      .i_run_nxt  (w_run_nxt),
      .i_wr       (w_wr[c]),
      .i_inc      (inc_data),
      .o_ovs_tick (ovs_tick[c]),
      .o_bit_tick (bit_tick[c])
    );
  end

endmodule

// File: tb/tb_uart_tick_gen.sv
// Self-checking bench for uart_tick_gen: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against an arithmetic tick/lock model.
module tb_uart_tick_gen;

  localparam int          NUM_CH   = 3;
  localparam int          ACC_W    = 24;
  localparam int          OVS      = 16;
  localparam int          LOCK_CYC = 1024;
  localparam int unsigned INC_DEF  = 3022624;
  localparam longint      WRAP     = 64'd1 << ACC_W;

  logic              osc_int = 1'b0;
  logic              rst = 1'b1;
  logic              stdby = 1'b0;
  logic              pll_lock = 1'b0;
  logic              inc_wr = 1'b0;
  logic [1:0]        inc_ch = '0;
  logic [ACC_W-1:0]  inc_data = '0;
  logic [NUM_CH-1:0] ovs_tick;
  logic [NUM_CH-1:0] bit_tick;
  logic              ready;

  int errors = 0;
  int checks = 0;
  int shown = 0;

  uart_tick_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .OVS         (OVS),
    .LOCK_CYC    (LOCK_CYC),
    .INC_DEFAULT (INC_DEF)
  ) dut (
    .osc_int  (osc_int),
    .rst      (rst),
    .stdby    (stdby),
    .pll_lock (pll_lock),
    .inc_wr   (inc_wr),
    .inc_ch   (inc_ch),
    .inc_data (inc_data),
    .ovs_tick (ovs_tick),
    .bit_tick (bit_tick),
    .ready    (ready)
  );

  always #5 osc_int = ~osc_int;

  // Reference: ready follows the length of the current lock streak; each channel is a phase
  // integer that emits one tick per 2^ACC_W of accumulated phase, every OVS-th one a bit tick.
  longint unsigned m_acc [NUM_CH];
  longint unsigned m_inc [NUM_CH];
  int              m_ncar[NUM_CH];
  int              m_streak = 0;
  bit              m_ready = 1'b0;
  bit [NUM_CH-1:0] m_ovs = '0;
  bit [NUM_CH-1:0] m_bit = '0;
  bit              m_valid = 1'b0;

  always @(posedge osc_int) begin
    bit prev, nready, enter, car;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_acc[c] = 0; m_inc[c] = INC_DEF; m_ncar[c] = 0;
      end
      m_streak = 0; m_ready = 0; m_ovs = '0; m_bit = '0; m_valid = 1'b1;
    end else begin
      prev = m_ready;
      if (pll_lock) m_streak = (m_streak >= LOCK_CYC + 2) ? m_streak : m_streak + 1;
      else          m_streak = 0;
      if (m_streak == LOCK_CYC + 1)      nready = 1'b1;
      else if (m_streak >= LOCK_CYC + 2) nready = !stdby;
      else                               nready = 1'b0;
      enter = nready && !prev;
      for (int c = 0; c < NUM_CH; c++) begin
        car = 1'b0;
        if (prev) begin
          m_acc[c] = m_acc[c] + m_inc[c];
          if (m_acc[c] >= WRAP) begin
            car = 1'b1;
            m_acc[c] = m_acc[c] - WRAP;
          end
        end
        if (car) m_ncar[c]++;
        m_ovs[c] = car && nready;
        m_bit[c] = car && nready && (m_ncar[c] % OVS == 0);
        if (enter) begin
          m_acc[c] = 0; m_ncar[c] = 0;
        end
      end
      if (inc_wr && (int'(inc_ch) < NUM_CH)) m_inc[inc_ch] = inc_data;
      m_ready = nready;
    end
  end

  always @(negedge osc_int) begin
    if (m_valid) begin
      checks++;
      if (ready !== m_ready || ovs_tick !== m_ovs || bit_tick !== m_bit) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL cycle_compare t=%0t: got ready=%b ovs=%b bit=%b, expected ready=%b ovs=%b bit=%b",
                   $time, ready, ovs_tick, bit_tick, m_ready, m_ovs, m_bit);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input longint act, input longint exp, input longint tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge osc_int);
      #1;
    end
  endtask

  task automatic wait_ready(output int n, input int budget);
    n = 0;
    while (!ready && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic write_inc(input int ch, input longint data);
    inc_wr = 1'b1; inc_ch = 2'(ch); inc_data = ACC_W'(data);
    step(1);
    inc_wr = 1'b0;
  endtask

  int f_ovs[NUM_CH], f_bit[NUM_CH], c_ovs[NUM_CH], c_bit[NUM_CH], ovs_at_bit[NUM_CH];

  // Observe n cycles starting just after the cycle in which ready was seen
  task automatic window(input int n);
    for (int c = 0; c < NUM_CH; c++) begin
      f_ovs[c] = -1; f_bit[c] = -1; c_ovs[c] = 0; c_bit[c] = 0; ovs_at_bit[c] = -1;
    end
    for (int k = 1; k <= n; k++) begin
      step(1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (ovs_tick[c]) begin
          c_ovs[c]++;
          if (f_ovs[c] < 0) f_ovs[c] = k;
        end
        if (bit_tick[c]) begin
          c_bit[c]++;
          if (f_bit[c] < 0) begin
            f_bit[c] = k; ovs_at_bit[c] = c_ovs[c];
          end
        end
      end
    end
  endtask

  initial begin
    int n;
    int hold;
    longint exp_ovs;

    step(2);
    chk("reset_ready", ready, 0);
    chk("reset_ovs", ovs_tick, 0);
    chk("reset_bit", bit_tick, 0);
    rst = 1'b0;
    step(1);

    // Rate setup during WAIT_LOCK, then lock-to-ready latency
    write_inc(0, 64'd1 << 22);
    pll_lock = 1'b1;
    step(1);
    wait_ready(n, 1500);
    chk("lock_to_ready", n, LOCK_CYC);

    window(20000);
    chk("ch0_first_ovs", f_ovs[0], 4);
    chk("ch0_first_bit", f_bit[0], 64);
    chk("ch0_ovs_at_first_bit", ovs_at_bit[0], 16);
    chk("ch0_ovs_count", c_ovs[0], 5000);
    chk("ch0_bit_count", c_bit[0], 312);
    exp_ovs = (longint'(20000) * INC_DEF) / WRAP;
    chk_near("ch1_default_ovs", c_ovs[1], exp_ovs, 1);
    chk_near("ch1_default_bit", c_bit[1], exp_ovs / OVS, 1);

    // Standby park and wake-up phase
    stdby = 1'b1;
    step(37);
    chk("park_ready", ready, 0);
    stdby = 1'b0;
    wait_ready(n, 10);
    chk("wake_latency", n, 1);
    window(100);
    chk("wake_first_ovs", f_ovs[0], 4);
    chk("wake_ovs_count", c_ovs[0], 25);

    // Reset mid-run, then a one-cycle lock glitch at settle count 500
    rst = 1'b1; pll_lock = 1'b0;
    step(2);
    rst = 1'b0;
    pll_lock = 1'b1;
    step(501);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(1);
    wait_ready(n, 1500);
    chk("glitch_relock_to_ready", n, LOCK_CYC);
    window(64);
    chk("reset_reverts_inc_ch0", c_ovs[0], (longint'(64) * INC_DEF) / WRAP);

    // Increment write in the same cycle lock falls
    inc_wr = 1'b1; inc_ch = 2'd0; inc_data = ACC_W'(64'd1 << 21); pll_lock = 1'b0;
    step(1);
    inc_wr = 1'b0;
    chk("lockloss_ready", ready, 0);
    pll_lock = 1'b1;
    step(1);
    wait_ready(n, 1500);
    chk("lockloss_relock_to_ready", n, LOCK_CYC);
    window(80);
    chk("lockloss_new_rate_first", f_ovs[0], 8);
    chk("lockloss_new_rate_count", c_ovs[0], 10);

    // Out-of-range channel write must change nothing
    write_inc(3, 1);
    window(80);
    chk("oor_ch0_count", c_ovs[0], 10);
    chk_near("oor_ch2_count", c_ovs[2], (longint'(80) * INC_DEF) / WRAP, 1);

    // Randomized traffic, checked by the per-cycle compare
    hold = 0;
    for (int i = 0; i < 15000; i++) begin
      int r;
      inc_wr = ($urandom_range(0, 15) == 0);
      inc_ch = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 7);
      if (r == 0)      inc_data = '0;
      else if (r == 1) inc_data = ACC_W'(64'd1 << 22);
      else             inc_data = ACC_W'($urandom_range(0, 32'h7FFFFF));
      if ($urandom_range(0, 199) == 0) stdby = ~stdby;
      if (hold > 0) begin
        hold--;
        pll_lock = (hold == 0);
      end else if ($urandom_range(0, 3999) == 0) begin
        hold = $urandom_range(1, 3);
        pll_lock = 1'b0;
      end
      rst = ($urandom_range(0, 9999) == 0);
      step(1);
    end
    inc_wr = 1'b0; rst = 1'b0; stdby = 1'b0; pll_lock = 1'b1;
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
